// File: rtl/reg_file_if.sv
// Request/response channel between the memory stage and the register file.
// The requester drives the i_* fields; the register file drives the o_* fields.
interface reg_file_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_CMD_WIDTH = 2
);
    logic [3:0]               i_reg;
    logic [DATA_WIDTH-1:0]    i_data;
    logic [REG_CMD_WIDTH-1:0] i_cmd;
    logic                     i_valid;
    logic                     i_res_ready;
    logic [DATA_WIDTH-1:0]    o_data;
    logic                     o_res_valid;
    logic                     o_ready;

    modport master (
        output i_reg, i_data, i_cmd, i_valid, i_res_ready,
        input  o_data, o_res_valid, o_ready
    );

    modport slave (
        input  i_reg, i_data, i_cmd, i_valid, i_res_ready,
        output o_data, o_res_valid, o_ready
    );
endinterface

// File: rtl/reg_file.sv
// 16-entry register file: one READ/WRITE per accepted request, READ answers 1 cycle later.
// A pending response holds o_data and drops o_ready until i_res_ready consumes it.
module reg_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_CMD_WIDTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);
    localparam int NUM_REGS = 16;

    localparam logic [REG_CMD_WIDTH-1:0] CMD_READ  = REG_CMD_WIDTH'(1);
    localparam logic [REG_CMD_WIDTH-1:0] CMD_WRITE = REG_CMD_WIDTH'(2);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic req_accept;
    logic is_read;
    logic is_write;

    always_comb begin
        req_accept = bus.i_valid && (state_q == IDLE);
        is_read    = req_accept && (bus.i_cmd == CMD_READ);
        is_write   = req_accept && (bus.i_cmd == CMD_WRITE);
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        regs_d  = regs_q;

        unique case (state_q)
            IDLE: begin
                if (is_read) begin
                    data_d  = regs_q[bus.i_reg];
                    state_d = RESP;
                end else if (is_write) begin
                    regs_d[bus.i_reg] = bus.i_data;
                end
            end
            RESP: begin
                // o_data is left untouched so the last result stays visible after consumption
                if (bus.i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_res_valid = (state_q == RESP);
    assign bus.o_ready     = (state_q == IDLE);

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: vector table plus hand sequences, read data checked through a scoreboard queue.
module tb_reg_file;
    localparam int DW = 32;

    localparam logic [1:0] C_NOP = 2'd0;
    localparam logic [1:0] C_RD  = 2'd1;
    localparam logic [1:0] C_WR  = 2'd2;
    localparam logic [1:0] C_RSV = 2'd3;

    logic clk;
    logic reset;

    reg_file_if #(.DATA_WIDTH(DW), .REG_CMD_WIDTH(2)) bus ();

    reg_file #(.DATA_WIDTH(DW), .REG_CMD_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    cmd;
        logic [3:0]    rg;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sb[$];
    logic          pending;
    int            n_cmp;
    int            n_err;

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: check outputs against the bench's view, drive inputs, advance the bench's view.
    task automatic tick(input logic rst, input logic v, input logic [1:0] cmd, input logic [3:0] r,
                        input logic [DW-1:0] d, input logic rr, input logic [DW-1:0] exp,
                        input string tag);
        @(negedge clk);
        check_bit({tag, ":res_valid"}, bus.o_res_valid, pending);
        check_bit({tag, ":ready"}, bus.o_ready, !pending);
        if (pending && sb.size() > 0)
            check_word({tag, ":data"}, bus.o_data, sb[0]);

        reset           = rst;
        bus.i_valid     = v;
        bus.i_cmd       = cmd;
        bus.i_reg       = r;
        bus.i_data      = d;
        bus.i_res_ready = rr;

        if (rst) begin
            pending = 1'b0;
            sb.delete();
        end else if (pending) begin
            if (rr) begin
                void'(sb.pop_front());
                pending = 1'b0;
            end
        end else if (v && cmd == C_RD) begin
            sb.push_back(exp);
            pending = 1'b1;
        end
    endtask

    task automatic idle(input logic rr, input string tag);
        tick(1'b0, 1'b0, C_NOP, 4'd0, '0, rr, '0, tag);
    endtask

    task automatic read_consume(input logic [3:0] r, input logic [DW-1:0] exp, input string tag);
        tick(1'b0, 1'b1, C_RD, r, '0, 1'b1, exp, tag);
        idle(1'b1, tag);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        pending = 1'b0;
        reset           = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_cmd       = C_NOP;
        bus.i_reg       = 4'd0;
        bus.i_data      = '0;
        bus.i_res_ready = 1'b0;

        // Reset with a READ presented: reset must win, no response appears
        for (int i = 0; i < 3; i++)
            tick(1'b1, 1'b1, C_RD, 4'd2, '0, 1'b0, '0, "rst_hold");
        idle(1'b0, "rst_exit");
        check_word("rst_odata", bus.o_data, '0);

        for (int i = 0; i < 16; i++)
            read_consume(4'(i), '0, "rd_zero");

        vecs.push_back('{C_WR, 4'd3, 32'hDEADBEEF, '0});
        vecs.push_back('{C_RD, 4'd3, '0, 32'hDEADBEEF});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{C_WR, 4'(i), 32'(i + 1), '0});
        vecs.push_back('{C_RSV, 4'd4, 32'hFFFF_FFFF, '0});
        vecs.push_back('{C_NOP, 4'd6, 32'hCAFE_F00D, '0});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{C_RD, 4'(i), '0, 32'(i + 1)});

        foreach (vecs[k]) begin
            if (vecs[k].cmd == C_RD)
                read_consume(vecs[k].rg, vecs[k].exp, "tbl_rd");
            else
                tick(1'b0, 1'b1, vecs[k].cmd, vecs[k].rg, vecs[k].data, 1'b1, '0, "tbl_wr");
        end

        // Response held for 4 cycles with i_res_ready low
        tick(1'b0, 1'b1, C_WR, 4'd5, 32'h12345678, 1'b0, '0, "hold_wr");
        tick(1'b0, 1'b1, C_RD, 4'd5, '0, 1'b0, 32'h12345678, "hold_rd");
        for (int i = 0; i < 4; i++)
            idle(1'b0, "hold_wait");
        idle(1'b1, "hold_take");
        idle(1'b0, "hold_after");

        // Requests while a response is pending are dropped
        tick(1'b0, 1'b1, C_RD, 4'd1, '0, 1'b0, 32'd2, "busy_rd");
        tick(1'b0, 1'b1, C_RD, 4'd2, '0, 1'b0, 32'hBAD0_BAD0, "busy_rd2");
        tick(1'b0, 1'b1, C_WR, 4'd2, 32'h55, 1'b0, '0, "busy_wr");
        idle(1'b1, "busy_take");
        idle(1'b1, "busy_none");
        idle(1'b0, "busy_none2");
        read_consume(4'd2, 32'd3, "busy_chk_r2");

        // Reset while a response is pending
        tick(1'b0, 1'b1, C_WR, 4'd7, 32'hAA, 1'b0, '0, "mid_wr");
        tick(1'b0, 1'b1, C_RD, 4'd9, '0, 1'b0, 32'd10, "mid_rd");
        idle(1'b0, "mid_wait");
        tick(1'b1, 1'b0, C_NOP, 4'd0, '0, 1'b0, '0, "mid_rst");
        idle(1'b0, "mid_exit");
        check_word("mid_odata", bus.o_data, '0);
        read_consume(4'd7, '0, "mid_r7");
        read_consume(4'd9, '0, "mid_r9");
        idle(1'b0, "end");

        check_word("sb_empty", 32'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
